// File: rtl/parity_pkg.sv
// Shared constants for the parity stream checker: default widths, parity sense
// encoding and the saturation limit used by the optional error counter.
package parity_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_sense_e;

  // Largest value representable in w bits, clamped to the 32-bit counter ceiling.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Balanced pairwise XOR reduction of a data word; the width is padded with zeros
// up to the next power of two so every level halves cleanly.
module parity_tree #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              par_o
);

  localparam int LEVELS = $clog2(DATA_W);
  localparam int N      = 1 << LEVELS;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = N >> l;
    logic [W-1:0] v;

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < W; j++) begin : g_bit
        if (j < DATA_W) begin : g_data
          assign v[j] = data_i[j];
        end else begin : g_pad
          assign v[j] = 1'b0;
        end
      end
    end else begin : g_node
      for (genvar j = 0; j < W; j++) begin : g_pair
        assign v[j] = g_lvl[l-1].v[2*j] ^ g_lvl[l-1].v[2*j+1];
      end
    end
  end

  assign par_o = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/parity_stream_checker.sv
// One-entry valid/ready pipeline stage that computes parity of each beat and
// flags mismatches. Define PARITY_ERR_CNT_EN to build the saturating error counter.
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_odd,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_par,
  output logic              out_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt
);

  logic              data_par;
  par_sense_e        sense;
  logic              beat_par;
  logic              beat_err;
  logic              accept;
  logic              transfer;
  logic              err_evt;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              par_q,   par_d;
  logic              err_q,   err_d;
  logic              sticky_q, sticky_d;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data_i (in_data),
    .par_o  (data_par)
  );

  assign sense    = par_sense_e'(mode_odd);
  assign beat_par = data_par ^ (sense == PAR_ODD);
  assign beat_err = beat_par ^ in_par;

  // The slot frees up in the same cycle the downstream takes the held beat.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = valid_q && out_ready;
  assign err_evt  = accept && beat_err;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    valid_d  = valid_q;
    data_d   = data_q;
    par_d    = par_q;
    err_d    = err_q;
    sticky_d = sticky_q;

    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
      par_d   = beat_par;
      err_d   = beat_err;
    end else if (transfer) begin
      valid_d = 1'b0;
    end

    if (err_evt) begin
      sticky_d = 1'b1;
    end else if (clr) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register in the
      // design samples its _d value from before the edge, regardless of order.
      valid_q  <= 1'b0;
      data_q   <= '0;
      par_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      par_q    <= par_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_par    = par_q;
  assign out_err    = err_q;
  assign err_sticky = sticky_q;

`ifdef PARITY_ERR_CNT_EN
  localparam logic [31:0]      CNT_MAX_W = cnt_max(CNT_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_W[CNT_W-1:0];

  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // A new error in the same cycle as clr restarts the count at one.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_evt) begin
      if (clr) begin
        err_cnt_d = CNT_W'(1);
      end else if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end else if (clr) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed bench for parity_stream_checker (DATA_W=8, CNT_W=2): a vector table for
// the streaming datapath plus hand-written backpressure, saturation and reset sequences.
module tb_parity_stream_checker;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst_n;
  logic              mode_odd;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par;
  logic              out_err;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  parity_stream_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_odd   (mode_odd),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_par    (out_par),
    .out_err    (out_err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic       par;
    logic       exp_par;
    logic       exp_err;
    logic       exp_sticky;
    logic [1:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected counter value depends on whether the counter is built.
  function automatic logic [1:0] cnt_exp(input logic [1:0] enabled_val);
`ifdef PARITY_ERR_CNT_EN
    return enabled_val;
`else
    return (enabled_val == 2'd0) ? enabled_val : 2'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] sat_seq [5];

  initial begin
    // mode, data, in_par, exp out_par, exp out_err, exp sticky, exp count (counter build)
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1};
    vecs[2] = '{1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1};
    vecs[3] = '{1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2};
    vecs[4] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2};
    vecs[5] = '{1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    vecs[6] = '{1'b0, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3};
    vecs[7] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3};
    sat_seq[0] = 2'd1; sat_seq[1] = 2'd2; sat_seq[2] = 2'd3;
    sat_seq[3] = 2'd3; sat_seq[4] = 2'd3;

    rst_n = 1'b0; mode_odd = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_data = '0; in_par = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset err_sticky", 64'(err_sticky), 64'd0);
    check("reset err_cnt", 64'(err_cnt), 64'd0);
    rst_n = 1'b1;

    // Full-throughput stream: one new beat per cycle, downstream always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mode_odd = vecs[i].mode;
      in_data  = vecs[i].data;
      in_par   = vecs[i].par;
      tick();
      check($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d out_data", i), 64'(out_data), 64'(vecs[i].data));
      check($sformatf("vec%0d out_par", i), 64'(out_par), 64'(vecs[i].exp_par));
      check($sformatf("vec%0d out_err", i), 64'(out_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d err_sticky", i), 64'(err_sticky), 64'(vecs[i].exp_sticky));
      check($sformatf("vec%0d err_cnt", i), 64'(err_cnt), 64'(cnt_exp(vecs[i].exp_cnt)));
    end

    in_valid = 1'b0;
    tick();
    check("drain out_valid", 64'(out_valid), 64'd0);
    check("drain sticky held", 64'(err_sticky), 64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr err_sticky", 64'(err_sticky), 64'd0);
    check("clr err_cnt", 64'(err_cnt), 64'd0);

    // Backpressure: 00 lands, then 03 and 07 wait until out_ready returns.
    mode_odd = 1'b0; in_valid = 1'b1; in_data = 8'h00; in_par = 1'b0;
    tick();
    check("bp first out_data", 64'(out_data), 64'h00);
    check("bp first out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0; in_data = 8'h03; in_par = 1'b0;
    #1;
    check("bp in_ready low", 64'(in_ready), 64'd0);
    mode_odd = 1'b1; clr = 1'b1;
    tick();
    check("bp hold1 out_data", 64'(out_data), 64'h00);
    check("bp hold1 out_par", 64'(out_par), 64'd0);
    check("bp hold1 out_err", 64'(out_err), 64'd0);
    check("bp hold1 out_valid", 64'(out_valid), 64'd1);
    clr = 1'b0;
    tick();
    check("bp hold2 out_data", 64'(out_data), 64'h00);
    check("bp hold2 out_par", 64'(out_par), 64'd0);
    mode_odd = 1'b0; out_ready = 1'b1;
    tick();
    check("bp second out_data", 64'(out_data), 64'h03);
    check("bp second out_par", 64'(out_par), 64'd0);
    check("bp second out_err", 64'(out_err), 64'd0);
    in_data = 8'h07; in_par = 1'b1;
    tick();
    check("bp third out_data", 64'(out_data), 64'h07);
    check("bp third out_par", 64'(out_par), 64'd1);
    check("bp third out_err", 64'(out_err), 64'd0);
    in_valid = 1'b0;
    tick();
    check("bp empty out_valid", 64'(out_valid), 64'd0);
    check("bp empty in_ready", 64'(in_ready), 64'd1);

    // Saturation with CNT_W=2, then clr racing a new error beat.
    mode_odd = 1'b0; in_valid = 1'b1; in_data = 8'h01; in_par = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("sat%0d out_err", k), 64'(out_err), 64'd1);
      check($sformatf("sat%0d err_cnt", k), 64'(err_cnt), 64'(cnt_exp(sat_seq[k])));
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr+err err_sticky", 64'(err_sticky), 64'd1);
    check("clr+err err_cnt", 64'(err_cnt), 64'(cnt_exp(2'd1)));
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr only err_sticky", 64'(err_sticky), 64'd0);

    // Asynchronous reset while a beat is held under backpressure.
    in_valid = 1'b1; in_data = 8'h5A; in_par = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_data = 8'hC3;
    tick();
    check("rst pre out_data", 64'(out_data), 64'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async out_valid", 64'(out_valid), 64'd0);
    check("rst async out_data", 64'(out_data), 64'd0);
    check("rst async out_par", 64'(out_par), 64'd0);
    check("rst async out_err", 64'(out_err), 64'd0);
    check("rst async in_ready", 64'(in_ready), 64'd1);
    tick();
    check("rst no accept", 64'(out_valid), 64'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("rst beat gone", 64'(out_valid), 64'd0);
    mode_odd = 1'b1; in_valid = 1'b1; in_data = 8'h0F; in_par = 1'b0;
    tick();
    in_valid = 1'b0;
    check("post rst out_data", 64'(out_data), 64'h0F);
    check("post rst out_par", 64'(out_par), 64'd1);
    check("post rst out_err", 64'(out_err), 64'd1);
    check("post rst err_sticky", 64'(err_sticky), 64'd1);
    check("post rst err_cnt", 64'(err_cnt), 64'(cnt_exp(2'd1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
